// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants for the seven-segment bus reader: active-low
//               glyph codes, capture FSM encodings and the scan-order step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0   = 7'h40;
    localparam logic [6:0] GLYPH_1   = 7'h79;
    localparam logic [6:0] GLYPH_2   = 7'h24;
    localparam logic [6:0] GLYPH_3   = 7'h30;
    localparam logic [6:0] GLYPH_4   = 7'h19;
    localparam logic [6:0] GLYPH_5   = 7'h12;
    localparam logic [6:0] GLYPH_6   = 7'h02;
    localparam logic [6:0] GLYPH_7   = 7'h78;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h10;
    localparam logic [6:0] GLYPH_A   = 7'h08;
    localparam logic [6:0] GLYPH_B   = 7'h03;
    localparam logic [6:0] GLYPH_C   = 7'h46;
    localparam logic [6:0] GLYPH_D   = 7'h21;
    localparam logic [6:0] GLYPH_E   = 7'h06;
    localparam logic [6:0] GLYPH_F   = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODE_BLANK = 4'hF;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_BAD  = 2'd2;

    // The driver scans 0,3,2,1,0,... so each step moves down one index mod 4.
    function automatic logic [1:0] next_index(input logic [1:0] idx);
        return idx - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_decode.sv
// ============================================================================
// Module      : seven_seg_glyph_decode
// Description : Combinational active-low glyph to hex-nibble decoder; any
//               pattern outside the table (including blank) yields 0 / not ok.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] nibble,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (segment)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                ok     = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
// Module      : seven_seg_capture
// Description : Debounces the scanned anode/cathode bus, decodes each digit
//               dwell to a nibble, and checks scan order and frame completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  segment,
    output logic [15:0] digits,
    output logic [3:0]  glyph_ok,
    output logic        frame_valid,
    output logic        anode_err,
    output logic        order_err
);

    localparam logic [7:0] c_settle = 8'(SETTLE);

    logic [10:0] prev_q,        prev_d;
    logic [7:0]  cnt_q,         cnt_d;
    logic [1:0]  state_q,       state_d;
    logic [2:0]  seq_q,         seq_d;
    logic [1:0]  last_idx_q,    last_idx_d;
    logic        last_vld_q,    last_vld_d;
    logic [15:0] digits_q,      digits_d;
    logic [3:0]  glyph_ok_q,    glyph_ok_d;
    logic        frame_valid_q, frame_valid_d;
    logic        anode_err_q,   anode_err_d;
    logic        order_err_q,   order_err_d;

    logic [10:0] w_sample;
    logic        w_same;
    logic        w_anode_chg;
    logic        w_stable_edge;
    logic        w_sel_valid;
    logic [1:0]  w_sel_idx;
    logic [1:0]  w_state_eff;
    logic        w_capture;
    logic        w_illegal;
    logic [3:0]  w_nibble;
    logic        w_glyph_ok;

    seven_seg_glyph_decode u_glyph_decode (
        .segment (segment),
        .nibble  (w_nibble),
        .ok      (w_glyph_ok)
    );

    assign w_sample    = {anode, segment};
    assign w_same      = (w_sample == prev_q);
    assign w_anode_chg = (anode != prev_q[10:7]);

    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 2'd0;
        case (anode)
            4'hE:    w_sel_idx = 2'd0;
            4'hD:    w_sel_idx = 2'd1;
            4'hB:    w_sel_idx = 2'd2;
            4'h7:    w_sel_idx = 2'd3;
            default: w_sel_valid = 1'b0;
        endcase
    end

    always_comb begin
        prev_d = w_sample;
        if (!w_same) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= c_settle) begin
            cnt_d = c_settle;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires only on the edge where the count first reaches SETTLE, so a long
    // dwell yields a single event; with SETTLE=1 a fresh value fires at once.
    assign w_stable_edge = (cnt_d == c_settle) && !(w_same && (cnt_q == c_settle));

    // Leaving HOLD/BAD happens on the change edge itself, so that same edge
    // can already be evaluated as HUNT when SETTLE is 1.
    always_comb begin
        case (state_q)
            ST_HOLD: w_state_eff = w_anode_chg ? ST_HUNT : ST_HOLD;
            ST_BAD:  w_state_eff = w_same ? ST_BAD : ST_HUNT;
            default: w_state_eff = ST_HUNT;
        endcase
    end

    assign w_capture = w_stable_edge && (w_state_eff == ST_HUNT) && w_sel_valid;
    assign w_illegal = w_stable_edge && (w_state_eff == ST_HUNT) && !w_sel_valid
                       && (anode != ANODE_BLANK);

    always_comb begin
        state_d       = w_state_eff;
        seq_d         = seq_q;
        last_idx_d    = last_idx_q;
        last_vld_d    = last_vld_q;
        digits_d      = digits_q;
        glyph_ok_d    = glyph_ok_q;
        frame_valid_d = 1'b0;
        anode_err_d   = 1'b0;
        order_err_d   = 1'b0;

        if (w_illegal) begin
            state_d     = ST_BAD;
            anode_err_d = 1'b1;
            last_vld_d  = 1'b0;
        end

        if (w_capture) begin
            state_d                   = ST_HOLD;
            digits_d[w_sel_idx*4 +: 4] = w_nibble;
            glyph_ok_d[w_sel_idx]     = w_glyph_ok;
            last_idx_d                = w_sel_idx;
            last_vld_d                = 1'b1;
            if (!last_vld_q) begin
                seq_d = 3'd1;
            end else if (w_sel_idx == next_index(last_idx_q)) begin
                if (seq_q == 3'd3) begin
                    frame_valid_d = 1'b1;
                    seq_d         = 3'd0;
                end else begin
                    seq_d = seq_q + 3'd1;
                end
            end else begin
                order_err_d = 1'b1;
                seq_d       = 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q        <= '0;
            cnt_q         <= '0;
            state_q       <= ST_HUNT;
            seq_q         <= '0;
            last_idx_q    <= '0;
            last_vld_q    <= 1'b0;
            digits_q      <= '0;
            glyph_ok_q    <= '0;
            frame_valid_q <= 1'b0;
            anode_err_q   <= 1'b0;
            order_err_q   <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            seq_q         <= seq_d;
            last_idx_q    <= last_idx_d;
            last_vld_q    <= last_vld_d;
            digits_q      <= digits_d;
            glyph_ok_q    <= glyph_ok_d;
            frame_valid_q <= frame_valid_d;
            anode_err_q   <= anode_err_d;
            order_err_q   <= order_err_d;
        end
    end

    assign digits      = digits_q;
    assign glyph_ok    = glyph_ok_q;
    assign frame_valid = frame_valid_q;
    assign anode_err   = anode_err_q;
    assign order_err   = order_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// ============================================================================
// Module      : tb_seven_seg_capture
// Description : Self-checking bench for seven_seg_capture with a dwell-level
//               reference model, directed scenarios and randomized dwells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_capture;

    localparam int SETTLE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  anode = 4'hF;
    logic [6:0]  segment = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  glyph_ok;
    logic        frame_valid;
    logic        anode_err;
    logic        order_err;

    seven_seg_capture #(.SETTLE(SETTLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .anode       (anode),
        .segment     (segment),
        .digits      (digits),
        .glyph_ok    (glyph_ok),
        .frame_valid (frame_valid),
        .anode_err   (anode_err),
        .order_err   (order_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_HUNT, M_HOLD, M_BAD} mmode_t;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] illegal_tab [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                     4'h8, 4'h9, 4'hA, 4'hC};

    // Reference model state, tracked per dwell
    mmode_t      m_mode;
    bit          m_last_vld;
    int          m_last;
    int          m_seq;
    logic [15:0] m_digits;
    logic [3:0]  m_gok;
    logic [3:0]  m_prev_anode;
    int          exp_fv_total, exp_ae_total, exp_oe_total;

    // Observations accumulated by the stimulus driver
    int obs_fv, obs_ae, obs_oe, timing_err, both_err;

    function automatic int glyph_value(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic int anode_digit(input logic [3:0] a);
        logic [3:0] pat;
        for (int i = 0; i < 4; i++) begin
            pat = ~(4'b0001 << i);
            if (a == pat) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode       = M_HUNT;
        m_last_vld   = 1'b0;
        m_last       = 0;
        m_seq        = 0;
        m_digits     = 16'h0000;
        m_gok        = 4'h0;
        m_prev_anode = 4'h0;
    endtask

    task automatic clear_obs();
        obs_fv = 0; obs_ae = 0; obs_oe = 0; timing_err = 0; both_err = 0;
        exp_fv_total = 0; exp_ae_total = 0; exp_oe_total = 0;
    endtask

    // Hold one input value for len edges; caller guarantees it differs from the last one.
    task automatic apply_dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        int d, g;
        bit fv, ae, oe;
        anode   = a;
        segment = s;
        for (int i = 1; i <= len; i++) begin
            @(posedge clock);
            #1;
            fv = 0; ae = 0; oe = 0;
            if (i == 1) begin
                if (m_mode == M_BAD) m_mode = M_HUNT;
                else if (m_mode == M_HOLD && a != m_prev_anode) m_mode = M_HUNT;
            end
            if (i == SETTLE && m_mode == M_HUNT) begin
                d = anode_digit(a);
                if (d >= 0) begin
                    g = glyph_value(s);
                    m_digits[4*d +: 4] = (g >= 0) ? 4'(g) : 4'h0;
                    m_gok[d]           = (g >= 0);
                    if (!m_last_vld) begin
                        m_seq = 1;
                    end else if (d == (m_last + 3) % 4) begin
                        m_seq++;
                        if (m_seq == 4) begin
                            fv    = 1;
                            m_seq = 0;
                        end
                    end else begin
                        oe    = 1;
                        m_seq = 1;
                    end
                    m_last     = d;
                    m_last_vld = 1'b1;
                    m_mode     = M_HOLD;
                end else if (a != 4'hF) begin
                    ae         = 1;
                    m_mode     = M_BAD;
                    m_last_vld = 1'b0;
                end
            end
            exp_fv_total += int'(fv);
            exp_ae_total += int'(ae);
            exp_oe_total += int'(oe);
            obs_fv += int'(frame_valid);
            obs_ae += int'(anode_err);
            obs_oe += int'(order_err);
            if (frame_valid && order_err) both_err++;
            if ({frame_valid, anode_err, order_err, digits, glyph_ok} !==
                {fv, ae, oe, m_digits, m_gok}) timing_err++;
        end
        m_prev_anode = a;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({digits, glyph_ok, frame_valid, anode_err, order_err} !== 23'h0) begin
            failures++;
            $display("FAIL reset_initial: got digits=%h glyph_ok=%h fv=%b ae=%b oe=%b, want all zero",
                     digits, glyph_ok, frame_valid, anode_err, order_err);
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({digits, glyph_ok, frame_valid, anode_err, order_err} !== 23'h0) begin
            failures++;
            $display("FAIL reset_held: got digits=%h glyph_ok=%h, want 0000/0", digits, glyph_ok);
        end
        reset = 1'b1;
        model_reset();
        clear_obs();
        apply_dwell(4'hF, 7'h7F, 6);
        checks++;
        if (obs_fv + obs_ae + obs_oe !== 0 || digits !== 16'h0) begin
            failures++;
            $display("FAIL reset_blank_idle: got pulses=%0d digits=%h, want 0 and 0000",
                     obs_fv + obs_ae + obs_oe, digits);
        end
    endtask

    task automatic test_in_order();
        clear_obs();
        apply_dwell(4'hE, 7'h40, 8);
        apply_dwell(4'h7, 7'h30, 8);
        apply_dwell(4'hB, 7'h24, 8);
        apply_dwell(4'hD, 7'h79, 8);
        checks++;
        if (digits !== 16'h3210) begin
            failures++;
            $display("FAIL in_order_digits: got %h want 3210", digits);
        end
        checks++;
        if (glyph_ok !== 4'hF) begin
            failures++;
            $display("FAIL in_order_glyph_ok: got %h want F", glyph_ok);
        end
        checks++;
        if (obs_fv !== 1 || obs_oe !== 0 || obs_ae !== 0) begin
            failures++;
            $display("FAIL in_order_pulses: got fv=%0d oe=%0d ae=%0d want 1/0/0", obs_fv, obs_oe, obs_ae);
        end
        checks++;
        if (timing_err !== 0) begin
            failures++;
            $display("FAIL in_order_timing: got %0d cycle disagreements want 0", timing_err);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        apply_dwell(4'hE, 7'h40, 8);
        apply_dwell(4'h7, 7'h30, 8);
        apply_dwell(4'hB, 7'h24, 3);
        apply_dwell(4'hF, 7'h7F, 3);
        apply_dwell(4'hB, 7'h24, 8);
        apply_dwell(4'hD, 7'h79, 8);
        checks++;
        if (obs_fv !== 1 || obs_oe !== 0) begin
            failures++;
            $display("FAIL glitch_pulses: got fv=%0d oe=%0d want 1/0", obs_fv, obs_oe);
        end
        checks++;
        if (timing_err !== 0) begin
            failures++;
            $display("FAIL glitch_timing: got %0d cycle disagreements want 0", timing_err);
        end
    endtask

    task automatic test_order_break();
        clear_obs();
        apply_dwell(4'hE, 7'h40, 8);
        apply_dwell(4'hB, 7'h24, 8);
        checks++;
        if (obs_oe !== 1 || obs_fv !== 0) begin
            failures++;
            $display("FAIL order_break_pulse: got oe=%0d fv=%0d want 1/0", obs_oe, obs_fv);
        end
        clear_obs();
        apply_dwell(4'hD, 7'h79, 8);
        apply_dwell(4'hE, 7'h40, 8);
        apply_dwell(4'h7, 7'h30, 8);
        checks++;
        if (obs_fv !== 1 || obs_oe !== 0) begin
            failures++;
            $display("FAIL order_break_resync: got fv=%0d oe=%0d want 1/0", obs_fv, obs_oe);
        end
        checks++;
        if (timing_err !== 0) begin
            failures++;
            $display("FAIL order_break_timing: got %0d cycle disagreements want 0", timing_err);
        end
    endtask

    task automatic test_illegal_anode();
        clear_obs();
        apply_dwell(4'hF, 7'h7F, 2);
        apply_dwell(4'h0, 7'h40, 14);
        checks++;
        if (obs_ae !== 1 || digits !== 16'h3210) begin
            failures++;
            $display("FAIL illegal_anode_err: got ae=%0d digits=%h want 1 and 3210", obs_ae, digits);
        end
        apply_dwell(4'hE, 7'h40, 8);
        checks++;
        if (obs_oe !== 0 || obs_ae !== 1) begin
            failures++;
            $display("FAIL illegal_recover: got oe=%0d ae=%0d want 0/1", obs_oe, obs_ae);
        end
        apply_dwell(4'h7, 7'h30, 8);
        apply_dwell(4'hB, 7'h24, 8);
        apply_dwell(4'hD, 7'h79, 8);
        checks++;
        if (obs_fv !== 1 || timing_err !== 0) begin
            failures++;
            $display("FAIL illegal_frame: got fv=%0d timing=%0d want 1/0", obs_fv, timing_err);
        end
    endtask

    task automatic test_bad_glyph();
        clear_obs();
        apply_dwell(4'hE, 7'h40, 8);
        apply_dwell(4'h7, 7'h7F, 8);
        apply_dwell(4'hB, 7'h24, 8);
        apply_dwell(4'hD, 7'h79, 8);
        checks++;
        if (digits !== 16'h0210 || glyph_ok !== 4'h7) begin
            failures++;
            $display("FAIL bad_glyph_capture: got digits=%h glyph_ok=%h want 0210/7", digits, glyph_ok);
        end
        checks++;
        if (obs_fv !== 1 || timing_err !== 0) begin
            failures++;
            $display("FAIL bad_glyph_frame: got fv=%0d timing=%0d want 1/0", obs_fv, timing_err);
        end
    endtask

    task automatic test_reset_mid_dwell();
        clear_obs();
        apply_dwell(4'hB, 7'h24, 2);
        reset = 1'b0;
        #1;
        checks++;
        if ({digits, glyph_ok, frame_valid, anode_err, order_err} !== 23'h0) begin
            failures++;
            $display("FAIL reset_mid_async: got digits=%h glyph_ok=%h want 0000/0", digits, glyph_ok);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        apply_dwell(4'hB, 7'h24, 8);
        apply_dwell(4'hD, 7'h79, 8);
        apply_dwell(4'hE, 7'h40, 8);
        checks++;
        if (obs_oe !== 0 || obs_fv !== 0) begin
            failures++;
            $display("FAIL reset_mid_restart: got oe=%0d fv=%0d want 0/0", obs_oe, obs_fv);
        end
        apply_dwell(4'h7, 7'h30, 8);
        checks++;
        if (obs_fv !== 1 || timing_err !== 0 || digits !== 16'h3210) begin
            failures++;
            $display("FAIL reset_mid_frame: got fv=%0d timing=%0d digits=%h want 1/0/3210",
                     obs_fv, timing_err, digits);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int r;
        clear_obs();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6 && m_last_vld) a = ~(4'b0001 << ((m_last + 3) % 4));
            else if (r < 8) a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 8) a = 4'hF;
            else a = illegal_tab[$urandom_range(0, 10)];
            if ($urandom_range(0, 4) != 0) s = glyphs[$urandom_range(0, 15)];
            else s = 7'($urandom);
            if (a == anode && s == segment) s = s ^ 7'h01;
            apply_dwell(a, s, $urandom_range(1, 9));
        end
        checks++;
        if (timing_err !== 0) begin
            failures++;
            $display("FAIL random_timing: got %0d cycle disagreements want 0", timing_err);
        end
        checks++;
        if (obs_fv !== exp_fv_total || obs_oe !== exp_oe_total || obs_ae !== exp_ae_total) begin
            failures++;
            $display("FAIL random_pulse_counts: got fv=%0d oe=%0d ae=%0d want %0d/%0d/%0d",
                     obs_fv, obs_oe, obs_ae, exp_fv_total, exp_oe_total, exp_ae_total);
        end
        checks++;
        if (both_err !== 0) begin
            failures++;
            $display("FAIL random_fv_oe_overlap: got %0d overlapping cycles want 0", both_err);
        end
    endtask

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_in_order();
        test_glitch();
        test_order_break();
        test_illegal_anode();
        test_bad_glyph();
        test_reset_mid_dwell();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
